// File: rtl/xintf.sv
`timescale 1ns/1ps
// DSP XINTF slave bridge: synchronises the DSP strobes to clk50M, captures write data,
// drives read data back onto the bus and emits one-cycle rd_fall/rd_end/wr_end events.
module xintf #(
    parameter int DW = 16
) (
    input  logic          clk50M,
    input  logic          rst_n,
    input  logic          xcs_n,
    input  logic          xrd,
    input  logic          xwe,
    inout  wire  [DW-1:0] xdata,
    input  logic [DW-1:0] xrd_data,
    output logic          rd_end,
    output logic          rd_fall,
    output logic [DW-1:0] xwr_data,
    output logic          wr_end
);

    logic          cs_s1, cs_s2;
    logic          rd_s1, rd_s2, rd_s3;
    logic          we_s1, we_s2, we_s3;
    logic [DW-1:0] d1, d2, d3;
    logic [DW-1:0] rd_q;
    logic          live;
    logic          rd_hi, we_hi;
    logic          rd_arm, we_arm;

    logic rd_fe, rd_re, we_fe, we_re;
    logic rd_go, rd_done, we_go, wr_done;

    assign rd_fe = rd_s3 & ~rd_s2;
    assign rd_re = ~rd_s3 & rd_s2;
    assign we_fe = we_s3 & ~we_s2;
    assign we_re = ~we_s3 & we_s2;

    // A fall only counts if the strobe was really seen high after reset,
    // so a strobe held low across reset cannot complete a transaction.
    assign rd_go   = rd_fe & rd_hi & ~cs_s2;
    assign we_go   = we_fe & we_hi & ~cs_s2;
    assign rd_done = rd_re & rd_arm & ~cs_s2;
    assign wr_done = we_re & we_arm & ~cs_s2;

    always_ff @(posedge clk50M or posedge rst_n) begin
        if (rst_n) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            rd_s1    <= 1'b1;
            rd_s2    <= 1'b1;
            rd_s3    <= 1'b1;
            we_s1    <= 1'b1;
            we_s2    <= 1'b1;
            we_s3    <= 1'b1;
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            rd_q     <= '0;
            live     <= 1'b0;
            rd_hi    <= 1'b0;
            we_hi    <= 1'b0;
            rd_arm   <= 1'b0;
            we_arm   <= 1'b0;
            rd_fall  <= 1'b0;
            rd_end   <= 1'b0;
            wr_end   <= 1'b0;
            xwr_data <= '0;
        end else begin
            cs_s1 <= xcs_n;
            cs_s2 <= cs_s1;
            rd_s1 <= xrd;
            rd_s2 <= rd_s1;
            rd_s3 <= rd_s2;
            we_s1 <= xwe;
            we_s2 <= we_s1;
            we_s3 <= we_s2;
            d1    <= xdata;
            d2    <= d1;
            d3    <= d2;
            live  <= 1'b1;

            // s1 holds preset values until the first edge after reset
            if (live && rd_s1)
                rd_hi <= 1'b1;
            if (live && we_s1)
                we_hi <= 1'b1;

            if (rd_go)
                rd_arm <= 1'b1;
            else if (rd_re)
                rd_arm <= 1'b0;

            if (we_go)
                we_arm <= 1'b1;
            else if (we_re)
                we_arm <= 1'b0;

            rd_fall <= rd_go;
            rd_end  <= rd_done;
            wr_end  <= wr_done;

            // d3 still holds the bus from the last edge where xwe was sampled low
            if (wr_done)
                xwr_data <= d3;

            if (!rd_s2)
                rd_q <= xrd_data;
        end
    end

    assign xdata = (!xcs_n && !xrd && xwe && !rst_n) ? rd_q : {DW{1'bz}};

endmodule

// File: tb/tb_xintf.sv
`timescale 1ns/1ps
// Randomised bench for xintf: a transaction-level model predicts event counts and write data.
module tb_xintf;

    logic        clk50M = 1'b0;
    logic        rst_n;
    logic        xcs_n;
    logic        xrd;
    logic        xwe;
    wire  [15:0] xdata;
    logic [15:0] xrd_data;
    logic        rd_end;
    logic        rd_fall;
    logic [15:0] xwr_data;
    logic        wr_end;

    logic        tb_en;
    logic [15:0] tb_drv;

    assign xdata = tb_en ? tb_drv : 16'hzzzz;

    xintf #(.DW(16)) dut (
        .clk50M   (clk50M),
        .rst_n    (rst_n),
        .xcs_n    (xcs_n),
        .xrd      (xrd),
        .xwe      (xwe),
        .xdata    (xdata),
        .xrd_data (xrd_data),
        .rd_end   (rd_end),
        .rd_fall  (rd_fall),
        .xwr_data (xwr_data),
        .wr_end   (wr_end)
    );

    always #10 clk50M = ~clk50M;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;

    int n_wr = 0, n_rf = 0, n_re = 0;
    int exp_wr = 0, exp_rf = 0, exp_re = 0;
    logic [15:0] exp_wdata = 16'h0000;
    bit prev_wr = 0, prev_rf = 0, prev_re = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk50M) cyc++;

    always @(negedge clk50M) begin
        if (wr_end) begin
            n_wr++;
            chk("wr_end_width", 32'(prev_wr), 0);
            chk("wr_end_latency_ok", 32'((cyc - rise_cyc) >= 2 && (cyc - rise_cyc) <= 4), 1);
        end
        if (rd_fall) begin
            n_rf++;
            chk("rd_fall_width", 32'(prev_rf), 0);
        end
        if (rd_end) begin
            n_re++;
            chk("rd_end_width", 32'(prev_re), 0);
        end
        prev_wr = wr_end;
        prev_rf = rd_fall;
        prev_re = rd_end;
    end

    task automatic check_state(input string tag);
        chk({tag, "_wr_cnt"}, 32'(n_wr), 32'(exp_wr));
        chk({tag, "_rf_cnt"}, 32'(n_rf), 32'(exp_rf));
        chk({tag, "_re_cnt"}, 32'(n_re), 32'(exp_re));
        chk({tag, "_xwr_data"}, 32'(xwr_data), 32'(exp_wdata));
    endtask

    // One DSP access; the bench drives the bus for writes and as a probe whenever
    // the DUT is expected to keep its drivers off during a read strobe.
    task automatic xfer(input bit do_wr, input bit do_rd, input logic [15:0] wv,
                        input logic [15:0] rv, input int lo);
        bit dut_drives;
        dut_drives = do_rd && !do_wr && !xcs_n;
        xrd_data = rv;
        if (do_wr) begin
            tb_drv = wv;
            tb_en  = 1'b1;
        end else if (do_rd && !dut_drives) begin
            tb_drv = 16'h0000;
            tb_en  = 1'b1;
        end
        @(negedge clk50M);
        #($urandom_range(1, 8));
        if (do_wr) xwe = 1'b0;
        if (do_rd) xrd = 1'b0;
        repeat (lo) @(negedge clk50M);
        if (dut_drives)
            chk("rd_bus_value", 32'(xdata), 32'(rv));
        else if (do_rd || do_wr)
            chk("bus_not_driven", 32'(xdata), 32'(tb_drv));
        #($urandom_range(1, 8));
        xwe = 1'b1;
        xrd = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(negedge clk50M);
        tb_en = 1'b0;
        if (do_rd && !xcs_n) begin
            tb_drv = 16'h0000;
            tb_en  = 1'b1;
            #1;
            chk("rd_hiz_after", 32'(xdata), 0);
            tb_en = 1'b0;
        end
        repeat (3) @(negedge clk50M);
        if (!xcs_n) begin
            if (do_wr) begin
                exp_wr++;
                exp_wdata = wv;
            end
            if (do_rd) begin
                exp_rf++;
                exp_re++;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] v;
        rst_n    = 1'b1;
        xcs_n    = 1'b0;
        xrd      = 1'b1;
        xwe      = 1'b1;
        xrd_data = 16'h0000;
        tb_en    = 1'b1;
        tb_drv   = 16'h5555;
        #50;
        chk("rst_xwr_data", 32'(xwr_data), 0);
        chk("rst_wr_end", 32'(wr_end), 0);
        chk("rst_rd_fall", 32'(rd_fall), 0);
        chk("rst_rd_end", 32'(rd_end), 0);
        chk("rst_bus_hiz", 32'(xdata), 32'h5555);
        #50;
        rst_n = 1'b0;
        tb_en = 1'b0;
        repeat (3) @(negedge clk50M);

        xfer(1, 0, 16'h5555, 16'h0000, 10);
        check_state("w5555");
        xfer(0, 1, 16'h0000, 16'hAAA1, 10);
        check_state("rAAA1");

        // read data updated one clock after rd_fall must reach the bus
        xrd_data = 16'hAAA1;
        @(negedge clk50M);
        #3;
        xrd = 1'b0;
        n = 0;
        while (!rd_fall && n < 20) begin
            @(negedge clk50M);
            n++;
        end
        chk("rd_fall_seen", 32'(n < 20), 1);
        @(negedge clk50M);
        xrd_data = 16'hAAA2;
        repeat (3) @(negedge clk50M);
        chk("rd_update_bus", 32'(xdata), 32'hAAA2);
        xrd = 1'b1;
        repeat (6) @(negedge clk50M);
        exp_rf++;
        exp_re++;
        check_state("rupd");

        xcs_n = 1'b1;
        repeat (3) @(negedge clk50M);
        xfer(1, 0, 16'h1234, 16'h0000, 10);
        xfer(0, 1, 16'h0000, 16'h4321, 8);
        check_state("cs_high");
        xcs_n = 1'b0;
        repeat (3) @(negedge clk50M);

        xfer(1, 0, 16'h0001, 16'h0000, 10);
        xfer(1, 0, 16'hFFFF, 16'h0000, 10);
        check_state("two_writes");

        // reset in the middle of a write aborts it silently
        tb_drv = 16'hBEEF;
        tb_en  = 1'b1;
        @(negedge clk50M);
        xwe = 1'b0;
        repeat (4) @(negedge clk50M);
        rst_n = 1'b1;
        repeat (2) @(negedge clk50M);
        chk("rst_mid_xwr_data", 32'(xwr_data), 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk50M);
        xwe = 1'b1;
        repeat (6) @(negedge clk50M);
        tb_en = 1'b0;
        exp_wdata = 16'h0000;
        check_state("abort");
        xfer(1, 0, 16'h00FF, 16'h0000, 10);
        check_state("after_abort");

        xfer(1, 1, 16'hC3C3, 16'h1111, 10);
        check_state("rd_we_both");

        for (int i = 0; i < 24; i++) begin
            logic new_cs;
            int op;
            new_cs = ($urandom_range(0, 3) == 0);
            if (new_cs != xcs_n) begin
                xcs_n = new_cs;
                repeat (3) @(negedge clk50M);
            end
            op = $urandom_range(0, 2);
            v  = 16'($urandom);
            xfer(op != 1, op != 0, v, 16'($urandom) | 16'h0001, $urandom_range(6, 12));
            check_state("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
